cpu64_ex_mem_reg: RTL and testbench
===================================

Name: cpu64_ex_mem_reg

Overview:
Execute-to-memory pipeline boundary. It captures the integer ALU result together with the destination-register and memory-access control for the instruction. The register decouples execute from the memory stage through a valid/ready handshake and a 2-entry skid buffer, so ready never passes combinationally across the stage. It also flags misaligned load/store addresses and exposes the resident result to the operand-forwarding network.

Parameters:
XLEN, 64, datapath width; must equal the codebase `XLEN.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous kill of all held entries
ex_valid_i  in  1  execute stage offers an instruction
ex_ready_o  out  1  stage can accept this cycle
ex_alu_result_i  in  XLEN  ALU result; memory address for loads/stores
ex_store_data_i  in  XLEN  rs2 data for stores
ex_pc_i  in  XLEN  instruction PC
ex_rd_addr_i  in  5  destination register
ex_rd_wen_i  in  1  writes rd
ex_mem_en_i  in  1  load or store
ex_mem_we_i  in  1  1 = store
ex_mem_size_i  in  2  0 byte, 1 half, 2 word, 3 dword
ex_mem_unsigned_i  in  1  zero-extend load
mem_valid_o  out  1  output entry valid
mem_ready_i  in  1  memory stage consumes
mem_alu_result_o, mem_store_data_o, mem_pc_o  out  XLEN each  registered copies
mem_rd_addr_o  out  5  registered copy
mem_rd_wen_o, mem_mem_en_o, mem_mem_we_o, mem_mem_unsigned_o  out  1 each  registered copies
mem_mem_size_o  out  2  registered copy
mem_misaligned_o  out  1  address not size-aligned (mem_en only)
fwd_valid_o  out  1  forwardable result present
fwd_rd_addr_o  out  5  forwarding tag
fwd_data_o  out  XLEN  forwarding data

Behaviour:
- Reset (rst_ni low, async): every output and internal register is 0. Exception: ex_ready_o is 1 once reset deasserts.
- Storage: an output entry (OUT) and a skid entry (SKID), each with a valid bit.
- ex_ready_o = !SKID.valid. It is a registered term only, with no combinational path from mem_ready_i.
- Input is accepted when ex_valid_i && ex_ready_o.
- OUT advances when !OUT.valid || mem_ready_i:
  - If SKID.valid: OUT <= SKID and SKID.valid <= 0. An input accepted in the same cycle goes into SKID. This cannot occur, because ready was 0.
  - Else, if input is accepted: OUT <= input.
  - Else: OUT.valid <= 0.
- When OUT is held (OUT.valid && !mem_ready_i) and input is accepted: SKID <= input.
- Latency: one cycle from accept to mem_valid_o when the stage is empty. Full throughput of 1 instruction per cycle while mem_ready_i = 1.
- Ordering: strict FIFO; SKID is always younger than OUT.
- Misalignment is computed on the input path and registered with the entry:
  - size 1: addr[0] != 0
  - size 2: addr[1:0] != 0
  - size 3: addr[2:0] != 0
  - size 0: never misaligned
  - Forced to 0 when ex_mem_en_i = 0.
- Forwarding:
  - fwd_valid_o = OUT.valid && OUT.rd_wen && OUT.rd_addr != 0 && !OUT.mem_en.
  - Load data is not yet available, so loads never forward. Stores have rd_wen = 0.
  - fwd_rd_addr_o = OUT.rd_addr; fwd_data_o = OUT.alu_result. Both are 0 when fwd_valid_o = 0.
- flush_i has priority over all other events. Next cycle OUT.valid = SKID.valid = 0. Any input offered in the flush cycle is dropped. ex_ready_o is 1 the cycle after a flush. Payload registers need not be cleared.
- Data outputs while mem_valid_o = 0 hold their last values; checkers must not sample them.
- mem_* outputs are stable while mem_valid_o && !mem_ready_i.
- rd_addr 0 with rd_wen = 1 passes through unchanged; the writeback stage discards it.

Decomposition:
- Memory-size encodings (MEM_SIZE_B/H/W/D) are added to cpu64_defs.vh alongside the ALU op codes.
- The payload is packed into one flat vector with localparam field offsets so both entries share a single width.
- One sub-module is natural: cpu64_misalign_chk, a combinational addr[2:0] × size → flag block, reused later by the AMO path.

Test Plan:
1. Reset with rst_ni low mid-transfer, while OUT and SKID are both valid → all outputs 0 asynchronously, and ex_ready_o = 1 after release.
2. Streaming with mem_ready_i = 1: three ADD results 0x10, 0x20, 0x30 to rd 5, 6, 7 → emerged one per cycle with 1-cycle latency, in order; fwd_data_o tracks each value.
3. Backpressure with mem_ready_i = 0 for 3 cycles while 3 instructions are offered → the first two are held (OUT, SKID), ex_ready_o drops to 0, and the third is stalled. On release, all three emerge in order with no loss or duplication.
4. Misalignment:
   - size 2, addr 0x1002 → mem_misaligned_o = 1
   - size 3, addr 0x1008 → 0
   - size 0, addr 0x1003 → 0
   - ex_mem_en_i = 0, addr 0x1 → 0
5. Forwarding:
   - load to rd 9 → fwd_valid_o = 0
   - ALU op to rd 0 → 0
   - ALU op 0xDEADBEEF to rd 9 → fwd_valid_o = 1, fwd_rd_addr_o = 9, fwd_data_o = 0xDEADBEEF
6. flush_i asserted while OUT and SKID are both valid and a new input is offered → next cycle mem_valid_o = 0 and ex_ready_o = 1, with no flushed instruction ever emerging.

Source files
------------

// File: rtl/cpu64_ex_mem_reg_pkg.sv
// Shared constants for the EX/MEM boundary: datapath width and memory access size codes.
package cpu64_ex_mem_reg_pkg;

  localparam int unsigned CPU64_XLEN = 64;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } mem_size_e;

endpackage

// File: rtl/cpu64_misalign_chk.sv
// Combinational natural-alignment check of a memory address against the access size.
module cpu64_misalign_chk
  import cpu64_ex_mem_reg_pkg::*;
(
  input  logic       mem_en_i,
  input  logic [2:0] addr_lo_i,
  input  logic [1:0] size_i,
  output logic       misaligned_o
);

  logic mis;

  always_comb begin
    mis = 1'b0;
    case (mem_size_e'(size_i))
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = addr_lo_i[0];
      MEM_SIZE_W: mis = |addr_lo_i[1:0];
      MEM_SIZE_D: mis = |addr_lo_i[2:0];
      default:    mis = 1'b0;
    endcase
  end

  assign misaligned_o = mem_en_i & mis;

endmodule

// File: rtl/cpu64_ex_mem_reg.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer, misalignment flag
// and forwarding tap. ex_ready_o depends only on registered state, never on mem_ready_i.
module cpu64_ex_mem_reg
  import cpu64_ex_mem_reg_pkg::*;
#(
  parameter int unsigned XLEN = CPU64_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [4:0]      ex_rd_addr_i,
  input  logic            ex_rd_wen_i,
  input  logic            ex_mem_en_i,
  input  logic            ex_mem_we_i,
  input  logic [1:0]      ex_mem_size_i,
  input  logic            ex_mem_unsigned_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] mem_alu_result_o,
  output logic [XLEN-1:0] mem_store_data_o,
  output logic [XLEN-1:0] mem_pc_o,
  output logic [4:0]      mem_rd_addr_o,
  output logic            mem_rd_wen_o,
  output logic            mem_mem_en_o,
  output logic            mem_mem_we_o,
  output logic            mem_mem_unsigned_o,
  output logic [1:0]      mem_mem_size_o,
  output logic            mem_misaligned_o,
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_rd_addr_o,
  output logic [XLEN-1:0] fwd_data_o
);

  // Flat payload layout shared by OUT and SKID.
  localparam int unsigned OFF_ALU = 0;
  localparam int unsigned OFF_SD  = XLEN;
  localparam int unsigned OFF_PC  = 2 * XLEN;
  localparam int unsigned OFF_RD  = 3 * XLEN;
  localparam int unsigned OFF_WEN = OFF_RD + 5;
  localparam int unsigned OFF_MEN = OFF_WEN + 1;
  localparam int unsigned OFF_MWE = OFF_MEN + 1;
  localparam int unsigned OFF_SZ  = OFF_MWE + 1;
  localparam int unsigned OFF_UNS = OFF_SZ + 2;
  localparam int unsigned OFF_MIS = OFF_UNS + 1;
  localparam int unsigned PL_W    = OFF_MIS + 1;

  logic [PL_W-1:0] in_pl;
  logic [PL_W-1:0] out_q, out_d, skid_q, skid_d;
  logic            out_v_q, out_v_d, skid_v_q, skid_v_d;
  logic            misaligned;
  logic            accept;

  cpu64_misalign_chk u_misalign_chk (
    .mem_en_i     (ex_mem_en_i),
    .addr_lo_i    (ex_alu_result_i[2:0]),
    .size_i       (ex_mem_size_i),
    .misaligned_o (misaligned)
  );

  always_comb begin
    in_pl = '0;
    in_pl[OFF_ALU +: XLEN] = ex_alu_result_i;
    in_pl[OFF_SD  +: XLEN] = ex_store_data_i;
    in_pl[OFF_PC  +: XLEN] = ex_pc_i;
    in_pl[OFF_RD  +: 5]    = ex_rd_addr_i;
    in_pl[OFF_WEN]         = ex_rd_wen_i;
    in_pl[OFF_MEN]         = ex_mem_en_i;
    in_pl[OFF_MWE]         = ex_mem_we_i;
    in_pl[OFF_SZ  +: 2]    = ex_mem_size_i;
    in_pl[OFF_UNS]         = ex_mem_unsigned_i;
    in_pl[OFF_MIS]         = misaligned;
  end

  // Gated by rst_ni so ready reads 0 while reset is held and 1 as soon as it lifts.
  assign ex_ready_o = ~skid_v_q & rst_ni;
  assign accept     = ex_valid_i & ex_ready_o;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || mem_ready_i) begin
      if (skid_v_q) begin
        // ready was low this cycle, so no input can collide with the skid drain
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        out_d   = in_pl;
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_pl;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign mem_valid_o        = out_v_q;
  assign mem_alu_result_o   = out_q[OFF_ALU +: XLEN];
  assign mem_store_data_o   = out_q[OFF_SD  +: XLEN];
  assign mem_pc_o           = out_q[OFF_PC  +: XLEN];
  assign mem_rd_addr_o      = out_q[OFF_RD  +: 5];
  assign mem_rd_wen_o       = out_q[OFF_WEN];
  assign mem_mem_en_o       = out_q[OFF_MEN];
  assign mem_mem_we_o       = out_q[OFF_MWE];
  assign mem_mem_size_o     = out_q[OFF_SZ  +: 2];
  assign mem_mem_unsigned_o = out_q[OFF_UNS];
  assign mem_misaligned_o   = out_q[OFF_MIS];

  // Loads have no data yet, so only ALU results with a real destination forward.
  assign fwd_valid_o   = out_v_q & out_q[OFF_WEN] & (|out_q[OFF_RD +: 5]) & ~out_q[OFF_MEN];
  assign fwd_rd_addr_o = fwd_valid_o ? out_q[OFF_RD +: 5] : 5'd0;
  assign fwd_data_o    = fwd_valid_o ? out_q[OFF_ALU +: XLEN] : '0;

endmodule

// File: tb/tb_cpu64_ex_mem_reg.sv
// Directed self-checking bench for the EX/MEM pipeline register.
module tb_cpu64_ex_mem_reg;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            ex_valid = 1'b0;
  logic            ex_ready;
  logic [XLEN-1:0] ex_alu = '0, ex_sd = '0, ex_pc = '0;
  logic [4:0]      ex_rd = '0;
  logic            ex_wen = 1'b0, ex_men = 1'b0, ex_mwe = 1'b0, ex_uns = 1'b0;
  logic [1:0]      ex_sz = '0;
  logic            mem_valid, mem_ready = 1'b0;
  logic [XLEN-1:0] mem_alu, mem_sd, mem_pc;
  logic [4:0]      mem_rd;
  logic            mem_wen, mem_men, mem_mwe, mem_uns, mem_mis;
  logic [1:0]      mem_sz;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  int nvec = 0;
  int nerr = 0;

  cpu64_ex_mem_reg #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_alu_result_i(ex_alu), .ex_store_data_i(ex_sd), .ex_pc_i(ex_pc),
    .ex_rd_addr_i(ex_rd), .ex_rd_wen_i(ex_wen), .ex_mem_en_i(ex_men),
    .ex_mem_we_i(ex_mwe), .ex_mem_size_i(ex_sz), .ex_mem_unsigned_i(ex_uns),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_alu_result_o(mem_alu), .mem_store_data_o(mem_sd), .mem_pc_o(mem_pc),
    .mem_rd_addr_o(mem_rd), .mem_rd_wen_o(mem_wen), .mem_mem_en_o(mem_men),
    .mem_mem_we_o(mem_mwe), .mem_mem_unsigned_o(mem_uns), .mem_mem_size_o(mem_sz),
    .mem_misaligned_o(mem_mis),
    .fwd_valid_o(fwd_valid), .fwd_rd_addr_o(fwd_rd), .fwd_data_o(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic wen, input logic men,
                       input logic we, input logic [1:0] sz, input logic [63:0] alu);
    ex_valid = 1'b1;
    ex_rd    = rd;
    ex_wen   = wen;
    ex_men   = men;
    ex_mwe   = we;
    ex_sz    = sz;
    ex_uns   = 1'b0;
    ex_alu   = alu;
    ex_sd    = ~alu;
    ex_pc    = 64'h8000 + {59'd0, rd};
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  initial begin
    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {63'd0, ex_ready}, 64'd1);

    // streaming at full rate
    mem_ready = 1'b1;
    offer(5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 64'h10);
    tick();
    chk("s0_valid", {63'd0, mem_valid}, 64'd1);
    chk("s0_alu", mem_alu, 64'h10);
    chk("s0_rd", {59'd0, mem_rd}, 64'd5);
    chk("s0_pc", mem_pc, 64'h8005);
    chk("s0_fwd", fwd_data, 64'h10);
    offer(5'd6, 1'b1, 1'b0, 1'b0, 2'd0, 64'h20);
    tick();
    chk("s1_alu", mem_alu, 64'h20);
    chk("s1_fwd_rd", {59'd0, fwd_rd}, 64'd6);
    chk("s1_fwd", fwd_data, 64'h20);
    offer(5'd7, 1'b1, 1'b0, 1'b0, 2'd0, 64'h30);
    tick();
    chk("s2_alu", mem_alu, 64'h30);
    chk("s2_sd", mem_sd, ~64'h30);
    chk("s2_fwd", fwd_data, 64'h30);
    idle();
    tick();
    chk("s3_drained", {63'd0, mem_valid}, 64'd0);

    // backpressure: OUT and SKID fill, third stalls
    mem_ready = 1'b0;
    offer(5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 64'h100);
    tick();
    chk("bp0_alu", mem_alu, 64'h100);
    chk("bp0_ready", {63'd0, ex_ready}, 64'd1);
    offer(5'd11, 1'b1, 1'b0, 1'b0, 2'd0, 64'h200);
    tick();
    chk("bp1_ready", {63'd0, ex_ready}, 64'd0);
    chk("bp1_hold", mem_alu, 64'h100);
    offer(5'd12, 1'b1, 1'b0, 1'b0, 2'd0, 64'h300);
    tick();
    chk("bp2_ready", {63'd0, ex_ready}, 64'd0);
    chk("bp2_hold", mem_alu, 64'h100);
    chk("bp2_hold_rd", {59'd0, mem_rd}, 64'd10);
    mem_ready = 1'b1;
    tick();
    chk("bp3_alu", mem_alu, 64'h200);
    chk("bp3_ready", {63'd0, ex_ready}, 64'd1);
    tick();
    chk("bp4_alu", mem_alu, 64'h300);
    chk("bp4_valid", {63'd0, mem_valid}, 64'd1);
    idle();
    tick();
    chk("bp5_drained", {63'd0, mem_valid}, 64'd0);

    // misalignment
    offer(5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 64'h1002);
    tick();
    chk("mis_w_1002", {63'd0, mem_mis}, 64'd1);
    chk("mis_w_size", {62'd0, mem_sz}, 64'd2);
    offer(5'd3, 1'b1, 1'b1, 1'b0, 2'd3, 64'h1008);
    tick();
    chk("mis_d_1008", {63'd0, mem_mis}, 64'd0);
    offer(5'd3, 1'b1, 1'b1, 1'b0, 2'd0, 64'h1003);
    tick();
    chk("mis_b_1003", {63'd0, mem_mis}, 64'd0);
    offer(5'd3, 1'b1, 1'b1, 1'b1, 2'd1, 64'h1005);
    tick();
    chk("mis_h_1005", {63'd0, mem_mis}, 64'd1);
    chk("mis_h_we", {63'd0, mem_mwe}, 64'd1);
    offer(5'd3, 1'b1, 1'b0, 1'b0, 2'd3, 64'h1);
    tick();
    chk("mis_noen", {63'd0, mem_mis}, 64'd0);

    // forwarding
    offer(5'd9, 1'b1, 1'b1, 1'b0, 2'd3, 64'h2000);
    tick();
    chk("fwd_load_valid", {63'd0, fwd_valid}, 64'd0);
    chk("fwd_load_data", fwd_data, 64'd0);
    chk("fwd_load_rd", {59'd0, fwd_rd}, 64'd0);
    offer(5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 64'h55);
    tick();
    chk("fwd_x0_valid", {63'd0, fwd_valid}, 64'd0);
    chk("x0_passthru_rd", {59'd0, mem_rd}, 64'd0);
    chk("x0_passthru_wen", {63'd0, mem_wen}, 64'd1);
    offer(5'd9, 1'b1, 1'b0, 1'b0, 2'd0, 64'hDEADBEEF);
    tick();
    chk("fwd_alu_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_alu_rd", {59'd0, fwd_rd}, 64'd9);
    chk("fwd_alu_data", fwd_data, 64'hDEADBEEF);
    idle();
    tick();

    // flush with OUT and SKID full and a new offer
    mem_ready = 1'b0;
    offer(5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 64'hA1);
    tick();
    offer(5'd21, 1'b1, 1'b0, 1'b0, 2'd0, 64'hA2);
    tick();
    chk("fl_pre_ready", {63'd0, ex_ready}, 64'd0);
    offer(5'd22, 1'b1, 1'b0, 1'b0, 2'd0, 64'hA3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_valid", {63'd0, mem_valid}, 64'd0);
    chk("fl_ready", {63'd0, ex_ready}, 64'd1);
    chk("fl_fwd", {63'd0, fwd_valid}, 64'd0);
    mem_ready = 1'b1;
    tick();
    chk("fl_none_emerge0", {63'd0, mem_valid}, 64'd0);
    tick();
    chk("fl_none_emerge1", {63'd0, mem_valid}, 64'd0);

    // async reset mid-transfer with OUT and SKID full
    mem_ready = 1'b0;
    offer(5'd13, 1'b1, 1'b0, 1'b0, 2'd0, 64'hB1);
    tick();
    offer(5'd14, 1'b1, 1'b0, 1'b0, 2'd0, 64'hB2);
    tick();
    chk("ar_pre_valid", {63'd0, mem_valid}, 64'd1);
    idle();
    rst_n = 1'b0;
    #2;
    chk("ar_valid", {63'd0, mem_valid}, 64'd0);
    chk("ar_alu", mem_alu, 64'd0);
    chk("ar_rd", {59'd0, mem_rd}, 64'd0);
    chk("ar_ready", {63'd0, ex_ready}, 64'd0);
    chk("ar_fwd", {63'd0, fwd_valid}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ar_release_ready", {63'd0, ex_ready}, 64'd1);
    mem_ready = 1'b1;
    tick();
    chk("ar_no_emerge", {63'd0, mem_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
